insn_loader: RTL and testbench



---
 rtl/insn_loader.sv | 164 ++++++++++++++++
 tb/tb_insn_loader.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/insn_loader.sv
// insn_loader: framed byte-stream loader writing a 2^ADDR_W x 32 instruction RAM; optional checksum via INSN_LOADER_CHECKSUM_EN.
// Latency: a data word is written on the edge accepting its 4th byte; the fetch port is combinational.
// Backpressure: none; in_ready rises one edge after reset release and stays high.
module insn_loader #(
  parameter int         ADDR_W = 10,
  parameter logic [7:0] SYNC   = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] fetch_addr,
  output logic [31:0] fetch_word,
  output logic        cpu_rst,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] words_loaded
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_COUNT, S_DATA, S_CSUM, S_RUN, S_ERR
  } state_t;

  state_t state, state_nxt;

  logic [31:0]       mem [DEPTH];
  logic [1:0]        bcnt;       // byte position inside the current 32-bit field
  logic [23:0]       shreg;      // first three bytes of the field, byte 0 ends up in [7:0]
  logic [ADDR_W-1:0] widx;       // RAM index for the next data word
  logic [31:0]       count;
  logic              accept;
  logic              last_byte;
  logic              is_sync;
  logic              last_word;
  logic [31:0]       field;      // complete little-endian field while its 4th byte is on in_data
`ifdef INSN_LOADER_CHECKSUM_EN
  logic [31:0]       csum;
`endif

  assign accept    = in_valid & in_ready;
  assign last_byte = (bcnt == 2'd3);
  assign is_sync   = (in_data == SYNC);
  assign field     = {in_data, shreg};
  assign last_word = ((words_loaded + 32'd1) == count);

  // Fetch port: out-of-range addresses return a zero word
  always_comb begin
    fetch_word = '0;
    if (fetch_addr[31:ADDR_W] == '0)
      fetch_word = mem[fetch_addr[ADDR_W-1:0]];
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; SYNC is only a frame start outside a frame
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept && is_sync) state_nxt = S_ADDR;
      S_ADDR:  if (accept && last_byte) state_nxt = S_COUNT;
      S_COUNT: begin
        if (accept && last_byte) begin
          if (field != '0) state_nxt = S_DATA;
`ifdef INSN_LOADER_CHECKSUM_EN
          else             state_nxt = S_CSUM;
`else
          else             state_nxt = S_RUN;
`endif
        end
      end
      S_DATA: begin
        if (accept && last_byte && last_word) begin
`ifdef INSN_LOADER_CHECKSUM_EN
          state_nxt = S_CSUM;
`else
          state_nxt = S_RUN;
`endif
        end
      end
      S_CSUM: begin
`ifdef INSN_LOADER_CHECKSUM_EN
        if (accept && last_byte) state_nxt = (field == csum) ? S_RUN : S_ERR;
`else
        state_nxt = S_IDLE;
`endif
      end
      S_RUN, S_ERR: if (accept && is_sync) state_nxt = S_ADDR;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    cpu_rst = (state != S_RUN);
    busy    = (state == S_ADDR) || (state == S_COUNT) || (state == S_DATA) || (state == S_CSUM);
`ifdef INSN_LOADER_CHECKSUM_EN
    err     = (state == S_ERR);
`else
    err     = 1'b0;
`endif
  end

  // Field assembly, word counters, done pulse and ready
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready     <= 1'b0;
      done         <= 1'b0;
      bcnt         <= '0;
      shreg        <= '0;
      widx         <= '0;
      count        <= '0;
      words_loaded <= '0;
`ifdef INSN_LOADER_CHECKSUM_EN
      csum         <= '0;
`endif
    end else begin
      in_ready <= 1'b1;
      done     <= (state_nxt == S_RUN) && (state != S_RUN);
      if (accept) begin
        case (state)
          S_IDLE, S_RUN, S_ERR: begin
            if (is_sync) begin
              bcnt         <= '0;
              words_loaded <= '0;
`ifdef INSN_LOADER_CHECKSUM_EN
              csum         <= '0;
`endif
            end
          end
          default: begin
            bcnt  <= bcnt + 2'd1;
            shreg <= {in_data, shreg[23:8]};
            if (last_byte) begin
              if (state == S_ADDR)  widx  <= field[ADDR_W-1:0];
              if (state == S_COUNT) count <= field;
              if (state == S_DATA) begin
                widx         <= widx + ADDR_W'(1);
                words_loaded <= words_loaded + 32'd1;
`ifdef INSN_LOADER_CHECKSUM_EN
                csum         <= csum + field;
`endif
              end
            end
          end
        endcase
      end
    end
  end

  // RAM write port; contents survive rst
  always_ff @(posedge clk) begin
    if (accept && (state == S_DATA) && last_byte)
      mem[widx] <= field;
  end

endmodule

// File: tb/tb_insn_loader.sv
module tb_insn_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] fetch_addr;
  logic [31:0] fetch_word;
  logic        cpu_rst;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] words_loaded;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  insn_loader #(.ADDR_W(10), .SYNC(8'hA5)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .fetch_addr(fetch_addr), .fetch_word(fetch_word),
    .cpu_rst(cpu_rst), .busy(busy), .done(done), .err(err),
    .words_loaded(words_loaded)
  );

  typedef struct {
    logic [31:0]      addr;
    logic [31:0]      cnt;
    logic [2:0][31:0] w;
    bit               bad_csum;
    int               stall;
    int               abort;
    bit               exp_run;
  } vec_t;

  typedef struct packed {
    logic [31:0] idx;
    logic [31:0] word;
  } sb_t;

  sb_t  sb_q[$];
  vec_t tbl[9];

  always @(posedge clk) if (done === 1'b1) done_cnt++;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] c,
                              input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                              input bit bad, input int stall, input int abort, input bit run);
    vec_t v;
    v.addr = a; v.cnt = c;
    v.w[0] = w0; v.w[1] = w1; v.w[2] = w2;
    v.bad_csum = bad; v.stall = stall; v.abort = abort; v.exp_run = run;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
  endtask

  task automatic peek(input logic [31:0] a, output logic [31:0] w);
    fetch_addr = a;
    #1;
    w = fetch_word;
  endtask

  task automatic drain_sb();
    sb_t e;
    logic [31:0] got;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      peek(e.idx, got);
      check("ram_content", got, e.word);
    end
  endtask

  task automatic send_frame(input vec_t v);
    logic [31:0] sum, idx, got;
    int d0;
    sum = 32'h0;
    d0  = done_cnt;
    send_byte(8'hA5);
    check("start_cpu_rst", 32'(cpu_rst), 32'd1);
    check("start_busy", 32'(busy), 32'd1);
    check("start_words_loaded", words_loaded, 32'd0);
    check("start_err", 32'(err), 32'd0);
    send_word(v.addr);
    send_word(v.cnt);
    for (int i = 0; i < int'(v.cnt); i++) begin
      if (v.abort != 0 && i == v.abort) return;
      idx = (v.addr + 32'(i)) & 32'h3FF;
      if (v.stall > 0 && i == 0) begin
        send_byte(v.w[i][7:0]);
        send_byte(v.w[i][15:8]);
        repeat (v.stall) @(negedge clk);
        check("stall_busy", 32'(busy), 32'd1);
        check("stall_words_loaded", words_loaded, 32'd0);
        check("stall_cpu_rst", 32'(cpu_rst), 32'd1);
        send_byte(v.w[i][23:16]);
        send_byte(v.w[i][31:24]);
      end else begin
        send_word(v.w[i]);
      end
      sum += v.w[i];
      sb_q.push_back({idx, v.w[i]});
      check("words_loaded_step", words_loaded, 32'(i + 1));
      peek(idx, got);
      check("fetch_after_write", got, v.w[i]);
    end
`ifdef INSN_LOADER_CHECKSUM_EN
    send_word(v.bad_csum ? 32'h0 : sum);
`endif
    check("end_done", 32'(done), 32'(v.exp_run));
    check("end_cpu_rst", 32'(cpu_rst), 32'(!v.exp_run));
    check("end_err", 32'(err), 32'(!v.exp_run));
    check("end_busy", 32'(busy), 32'd0);
    check("end_words_loaded", words_loaded, v.cnt);
    @(negedge clk);
    check("done_pulse_count", 32'(done_cnt - d0), 32'(v.exp_run));
    check("done_low_after", 32'(done), 32'd0);
    drain_sb();
  endtask

  initial begin
    logic [31:0] got;
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; fetch_addr = 32'h5;

    tbl[0] = mk(32'h100, 3, 32'h1C8A0100, 32'h44C930C6, 32'h38E00000, 0, 0, 0, 1);
`ifdef INSN_LOADER_CHECKSUM_EN
    tbl[1] = mk(32'h100, 3, 32'h1C8A0100, 32'h44C930C6, 32'h38E00000, 1, 0, 0, 0);
`else
    tbl[1] = mk(32'h100, 3, 32'h1C8A0100, 32'h44C930C6, 32'h38E00000, 1, 0, 0, 1);
`endif
    tbl[2] = mk(32'h100, 3, 32'h1C8A0100, 32'h44C930C6, 32'h38E00000, 0, 0, 0, 1);
    tbl[3] = mk(32'h3FF, 2, 32'h00000011, 32'h00000022, 32'h0, 0, 0, 0, 1);
    tbl[4] = mk(32'h080, 3, 32'hAAAA0001, 32'hBBBB0002, 32'hCCCC0003, 0, 0, 2, 0);
    tbl[5] = mk(32'h080, 3, 32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F, 0, 0, 0, 1);
    tbl[6] = mk(32'h200, 0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 1);
    tbl[7] = mk(32'h300, 2, 32'hDEADBEEF, 32'h00A5A5A5, 32'h0, 0, 50, 0, 1);
    tbl[8] = mk(32'hFFFF0010, 1, 32'hCAFEF00D, 32'h0, 32'h0, 0, 0, 0, 1);

    // Reset state
    #12;
    check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_words_loaded", words_loaded, 32'd0);
    check("rst_fetch_word", fetch_word, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("in_ready_before_edge", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("in_ready_after_edge", 32'(in_ready), 32'd1);

    // Non-SYNC bytes in IDLE are ignored
    send_byte(8'h00);
    send_byte(8'h37);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_cpu_rst", 32'(cpu_rst), 32'd1);
    check("idle_words_loaded", words_loaded, 32'd0);

    for (int r = 0; r < 9; r++) begin
      send_frame(tbl[r]);
      if (tbl[r].abort != 0) begin
        // Asynchronous reset mid-frame: outputs drop immediately, RAM keeps written words
        #2;
        rst = 1'b1;
        #1;
        check("abort_cpu_rst", 32'(cpu_rst), 32'd1);
        check("abort_words_loaded", words_loaded, 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        drain_sb();
      end
      if (r == 3) begin
        peek(32'h400, got);
        check("fetch_out_of_range", got, 32'd0);
        peek(32'hFFFF_FFFF, got);
        check("fetch_far_out_of_range", got, 32'd0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
